// File: rtl/shift_unit_arbiter.sv
// Two-port arbiter in front of a shared combinational barrel shifter.
// Define SHIFT_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module shift_unit_arbiter #(
    parameter int unsigned DW   = 32,
    parameter int unsigned TAGW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [9:0]        req_op,
    input  logic [2*DW-1:0]   req_a,
    input  logic [2*DW-1:0]   req_b,
    input  logic [2*TAGW-1:0] req_tag,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DW-1:0]     rsp_data,
    output logic [TAGW-1:0]   rsp_tag,
    output logic [4:0]        sh_op,
    output logic [DW-1:0]     sh_a,
    output logic [DW-1:0]     sh_b,
    input  logic [DW-1:0]     sh_res,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;
    logic [TAGW-1:0]   rsp_tag_q, rsp_tag_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic [4:0]        sh_op_q, sh_op_d;
    logic [DW-1:0]     sh_a_q, sh_a_d;
    logic [DW-1:0]     sh_b_q, sh_b_d;
    logic              owner_q, owner_d;
    logic              grant;
    logic              any_valid;

    assign any_valid = |req_valid;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    assign grant = ~req_valid[0];
`else
    logic rr_ptr_q, rr_ptr_d;

    // Tie goes to rr_ptr; a lone requester always wins.
    assign grant = (&req_valid) ? rr_ptr_q : req_valid[1];
`endif

    // Gated by rst_n so ready is low while reset is held, even with valid inputs.
    assign req_ready = (rst_n && state_q == StIdle && any_valid) ?
                       (grant ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        tag_d       = tag_q;
        sh_op_d     = sh_op_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        owner_d     = owner_q;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    sh_op_d = grant ? req_op[9:5]          : req_op[4:0];
                    sh_a_d  = grant ? req_a[2*DW-1:DW]     : req_a[DW-1:0];
                    sh_b_d  = grant ? req_b[2*DW-1:DW]     : req_b[DW-1:0];
                    tag_d   = grant ? req_tag[2*TAGW-1:TAGW] : req_tag[TAGW-1:0];
                    owner_d = grant;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
                    rr_ptr_d = ~grant;
`endif
                    state_d = StExec;
                end
            end
            StExec: begin
                rsp_data_d  = sh_res;
                rsp_tag_d   = tag_q;
                rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            tag_q       <= '0;
            sh_op_q     <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            owner_q     <= 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            tag_q       <= tag_d;
            sh_op_q     <= sh_op_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            owner_q     <= owner_d;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign sh_op     = sh_op_q;
    assign sh_a      = sh_a_q;
    assign sh_b      = sh_b_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed, table-driven bench for shift_unit_arbiter with a behavioural shifter attached.
module tb_shift_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_tag;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic [4:0]  sh_op;
    logic [31:0] sh_a;
    logic [31:0] sh_b;
    logic [31:0] sh_res;
    logic        busy;

    int errors = 0;
    int checks = 0;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    always #5 clk = ~clk;

    shift_unit_arbiter #(.DW(32), .TAGW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .sh_op     (sh_op),
        .sh_a      (sh_a),
        .sh_b      (sh_b),
        .sh_res    (sh_res),
        .busy      (busy)
    );

    // Shared shifter: 00 sll, 01 right (arith when b[10]), 10 srl, 11 sra.
    always_comb begin
        sh_res = '0;
        case (sh_op[3:2])
            2'b00: sh_res = sh_a << sh_b[4:0];
            2'b01: sh_res = sh_b[10] ? 32'($signed(sh_a) >>> sh_b[4:0]) : sh_a >> sh_b[4:0];
            2'b10: sh_res = sh_a >> sh_b[4:0];
            default: sh_res = 32'($signed(sh_a) >>> sh_b[4:0]);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tag);
        req_valid[p]       = 1'b1;
        req_op[p*5 +: 5]   = op;
        req_a[p*32 +: 32]  = a;
        req_b[p*32 +: 32]  = b;
        req_tag[p*4 +: 4]  = tag;
    endtask

    // Entered at posedge+1 with the DUT idle and the expected winner's request driven.
    task automatic serve(input int p, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] exp_data, input int stall, input string name);
        logic [1:0] m;
        m = (p == 1) ? 2'b10 : 2'b01;
        check({name, " grant"}, 32'(req_ready), 32'(m));
        check({name, " idle busy"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({name, " exec ready"}, 32'(req_ready), 32'd0);
        check({name, " exec busy"}, 32'(busy), 32'd1);
        check({name, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, " sh_op"}, 32'(sh_op), 32'(op));
        check({name, " sh_a"}, sh_a, a);
        check({name, " sh_b"}, sh_b, b);
        @(posedge clk); #1;
        check({name, " rsp_valid"}, 32'(rsp_valid), 32'(m));
        check({name, " rsp_data"}, rsp_data, exp_data);
        check({name, " rsp_tag"}, 32'(rsp_tag), 32'(tag));
        for (int i = 0; i < stall; i++) begin
            rsp_ready = ~m;
            @(posedge clk); #1;
            check({name, " stall rsp_valid"}, 32'(rsp_valid), 32'(m));
            check({name, " stall rsp_data"}, rsp_data, exp_data);
            check({name, " stall rsp_tag"}, 32'(rsp_tag), 32'(tag));
            check({name, " stall ready"}, 32'(req_ready), 32'd0);
            check({name, " stall busy"}, 32'(busy), 32'd1);
        end
        rsp_ready = m;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        check({name, " done rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, " done busy"}, 32'(busy), 32'd0);
        check({name, " sh_a hold"}, sh_a, a);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " req_ready"}, 32'(req_ready), 32'd0);
        check({name, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, " rsp_data"}, rsp_data, 32'd0);
        check({name, " rsp_tag"}, 32'(rsp_tag), 32'd0);
        check({name, " sh_op"}, 32'(sh_op), 32'd0);
        check({name, " sh_a"}, sh_a, 32'd0);
        check({name, " sh_b"}, sh_b, 32'd0);
        check({name, " busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          port;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 5'b00000, 32'h0000_0001, 32'd31,         4'h1, 32'h8000_0000};
        vecs[1] = '{1, 5'b00100, 32'h8000_0000, 32'h0000_0404, 4'h9, 32'hF800_0000};
        vecs[2] = '{0, 5'b01000, 32'hF000_000F, 32'd4,          4'h2, 32'h0F00_0000};
        vecs[3] = '{1, 5'b01100, 32'h8000_0010, 32'hFFFF_FFE1, 4'hE, 32'hC000_0008};
        vecs[4] = '{0, 5'b00100, 32'h8000_0000, 32'h0000_0004, 4'h7, 32'h0800_0000};
        vecs[5] = '{1, 5'b00000, 32'h1234_5678, 32'd0,          4'hA, 32'h1234_5678};

        req_valid = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 2'b00;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle no req ready", 32'(req_ready), 32'd0);

        for (int i = 0; i < 6; i++) begin
            set_req(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            #1;
            serve(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp,
                  0, $sformatf("vec%0d", i));
            req_valid = 2'b00;
        end

        // Both ports valid from reset; port 0 first response is stalled 5 cycles.
        do_reset();
        set_req(0, 5'b00000, 32'h0000_0001, 32'd1, 4'h3);
        set_req(1, 5'b01000, 32'h0000_0100, 32'd4, 4'h5);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (FixedPrio || (i % 2 == 0))
                serve(0, 5'b00000, 32'h0000_0001, 32'd1, 4'h3, 32'h0000_0002,
                      (i == 0) ? 5 : 0, $sformatf("tie%0d p0", i));
            else
                serve(1, 5'b01000, 32'h0000_0100, 32'd4, 4'h5, 32'h0000_0010,
                      0, $sformatf("tie%0d p1", i));
        end
        req_valid = 2'b00;

        // Reset asserted while the shifter operation is in EXEC.
        set_req(1, 5'b01100, 32'h8000_0000, 32'd8, 4'hB);
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("post reset rsp_valid%0d", i), 32'(rsp_valid), 32'd0);
            check($sformatf("post reset busy%0d", i), 32'(busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
